mem_port_arbiter: RTL and testbench

- Shares one single-ported, variable-latency word memory between the pipeline's instruction-fetch port and its data-memory port.
- Sits between the fetch/memory stages and a unified backing memory.
- Arbitrates requests, with data priority and a fetch anti-starvation bound.
- Sequences each access through a req/ack handshake, returns registered completions, and flags misalignment and timeouts for the hazard unit.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_arb_timer.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the instruction/data memory port arbiter.
// The width helper returns at least one bit so degenerate parameters still elaborate.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } arb_gnt_e;

    localparam logic [31:0] ERR_WORD_DEFAULT = 32'hDEADBEEF;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, data port, backing-memory port and error flags of the arbiter.
// The slave view belongs to the arbiter; the master view is the surrounding pipeline and memory.
interface mem_port_arbiter_if;

    logic        if_req;
    logic [29:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_valid;

    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    logic        err_misalign;
    logic        err_timeout;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
        output if_rdata, if_valid, dm_rdata, dm_valid,
        output mem_req, mem_we, mem_addr, mem_wdata, err_misalign, err_timeout
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_valid, dm_rdata, dm_valid,
        input  mem_req, mem_we, mem_addr, mem_wdata, err_misalign, err_timeout
    );

endinterface

// File: rtl/mem_arb_timer.sv
// Access watchdog: counts down the remaining busy cycles and flags the cycle in which
// the TIMEOUT-th busy cycle is reached. TIMEOUT = 0 never expires.
module mem_arb_timer #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned W       = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [W-1:0] LOAD_VAL = (TIMEOUT == 0) ? '0 : W'(TIMEOUT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (TIMEOUT != 0) && en_i && (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency word memory between instruction fetch and data access,
// with data priority bounded by STARVE_MAX consecutive grants while a fetch waits.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 255,
    parameter logic [31:0] ERR_WORD   = ERR_WORD_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);

    localparam int unsigned     SW         = cnt_width(STARVE_MAX);
    localparam int unsigned     TW         = cnt_width(TIMEOUT);
    localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);

    arb_state_e  state_q, state_d;
    arb_gnt_e    gnt_d;
    logic        grant;
    logic        ack_hit;
    logic        tmo_hit;
    logic        busy;
    logic        tmr_expired;

    logic [SW-1:0] starve_q, starve_d;

    logic        mem_req_q;
    logic        mem_we_q;
    logic [29:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] if_rdata_q;
    logic [31:0] dm_rdata_q;
    logic        if_valid_q;
    logic        dm_valid_q;
    logic        err_misalign_q;
    logic        err_timeout_q;

    assign busy = (state_q == BUSY_I) || (state_q == BUSY_D);

    // Grant decision and access sequencing; an ack beats a simultaneous timeout.
    always_comb begin
        state_d = state_q;
        gnt_d   = GNT_I;
        grant   = 1'b0;
        ack_hit = 1'b0;
        tmo_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.dm_req && (!bus.if_req || (starve_q < STARVE_LIM))) begin
                    grant   = 1'b1;
                    gnt_d   = GNT_D;
                    state_d = BUSY_D;
                end else if (bus.if_req) begin
                    grant   = 1'b1;
                    gnt_d   = GNT_I;
                    state_d = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (bus.mem_ack) begin
                    ack_hit = 1'b1;
                    state_d = RESP;
                end else if (tmr_expired) begin
                    tmo_hit = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (grant) begin
            if ((gnt_d == GNT_D) && bus.if_req) begin
                starve_d = (starve_q < STARVE_LIM) ? starve_q + 1'b1 : starve_q;
            end else begin
                starve_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered memory request, completion data and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q       <= '0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            if_rdata_q     <= '0;
            dm_rdata_q     <= '0;
            if_valid_q     <= 1'b0;
            dm_valid_q     <= 1'b0;
            err_misalign_q <= 1'b0;
            err_timeout_q  <= 1'b0;
        end else begin
            starve_q   <= starve_d;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            if (grant) begin
                mem_req_q   <= 1'b1;
                mem_we_q    <= (gnt_d == GNT_D) && bus.dm_we;
                mem_addr_q  <= (gnt_d == GNT_D) ? bus.dm_addr[31:2] : bus.if_addr;
                mem_wdata_q <= bus.dm_wdata;
                if ((gnt_d == GNT_D) && (bus.dm_addr[1:0] != 2'b00)) begin
                    err_misalign_q <= 1'b1;
                end
            end
            if (ack_hit || tmo_hit) begin
                mem_req_q <= 1'b0;
                if (state_q == BUSY_I) begin
                    if_rdata_q <= ack_hit ? bus.mem_rdata : ERR_WORD;
                    if_valid_q <= 1'b1;
                end else begin
                    if (!mem_we_q) begin
                        dm_rdata_q <= ack_hit ? bus.mem_rdata : ERR_WORD;
                    end
                    dm_valid_q <= 1'b1;
                end
                if (tmo_hit) begin
                    err_timeout_q <= 1'b1;
                end
            end
        end
    end

    mem_arb_timer #(
        .TIMEOUT (TIMEOUT),
        .W       (TW)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (state_q == RESP),
        .load_i    (grant),
        .en_i      (busy),
        .expired_o (tmr_expired)
    );

    assign bus.mem_req      = mem_req_q;
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.if_rdata     = if_rdata_q;
    assign bus.if_valid     = if_valid_q;
    assign bus.dm_rdata     = dm_rdata_q;
    assign bus.dm_valid     = dm_valid_q;
    assign bus.err_misalign = err_misalign_q;
    assign bus.err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by a randomized
// run scored against a transaction-level model of the arbitration and memory contents.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int          STARVE_MAX = 4;
    localparam int          TIMEOUT    = 8;
    localparam logic [31:0] ERR_WORD   = 32'hDEADBEEF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(
        .STARVE_MAX (STARVE_MAX),
        .TIMEOUT    (TIMEOUT),
        .ERR_WORD   (ERR_WORD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] mem_arr [0:255];
    logic [31:0] ref_mem [0:255];
    logic [31:0] exp_dm_rdata;
    int ack_delay    = 0;
    bit ack_en       = 1'b1;
    int late_ack_tok = 0;

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'h2008000A : (32'hA5000000 ^ (i * 32'h00010203));
    endfunction

    function automatic logic [131:0] outs();
        return {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.if_rdata,
                bus.if_valid, bus.dm_rdata, bus.dm_valid, bus.err_misalign, bus.err_timeout};
    endfunction

    // Backing memory: acks ack_delay cycles into an access; a token bump injects a stray ack.
    initial begin : responder
        int busy_cnt;
        int seen;
        busy_cnt = 0;
        seen     = 0;
        for (int i = 0; i < 256; i++) mem_arr[i] = init_word(i);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (late_ack_tok != seen) begin
                seen          = late_ack_tok;
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = 32'h0BAD0BAD;
            end else if (rst || !bus.mem_req) begin
                busy_cnt = 0;
            end else begin
                if (ack_en && busy_cnt == ack_delay) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = mem_arr[bus.mem_addr[7:0]];
                    if (bus.mem_we) mem_arr[bus.mem_addr[7:0]] = bus.mem_wdata;
                end
                busy_cnt++;
            end
        end
    end

    task automatic drop_all();
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        bus.dm_we  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drop_all();
        bus.if_addr  = '0;
        bus.dm_addr  = '0;
        bus.dm_wdata = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if (outs() !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected 0", outs());
        end
        rst = 1'b0;
        exp_dm_rdata = '0;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        int n;
        ack_en = 1'b1;
        ack_delay = 2;
        bus.if_addr = 30'h4;
        bus.if_req  = 1'b1;
        n = 0;
        while (!bus.mem_req && n < 20) begin @(negedge clk); n++; end
        vectors++;
        if ({bus.mem_req, bus.mem_addr, bus.mem_we} !== {1'b1, 30'h4, 1'b0}) begin
            miscompares++;
            $display("FAIL fetch_grant: got req=%b addr=%h we=%b expected req=1 addr=4 we=0",
                     bus.mem_req, bus.mem_addr, bus.mem_we);
        end
        n = 0;
        while (bus.mem_req && n < 300) begin n++; @(negedge clk); end
        vectors++;
        if (n != 3 || bus.if_valid !== 1'b1 || bus.if_rdata !== ref_mem[4]) begin
            miscompares++;
            $display("FAIL fetch_complete: got busy=%0d valid=%b rdata=%h expected busy=3 valid=1 rdata=%h",
                     n, bus.if_valid, bus.if_rdata, ref_mem[4]);
        end
        bus.if_req = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus.if_valid, bus.err_misalign, bus.err_timeout} !== 3'b000) begin
            miscompares++;
            $display("FAIL fetch_pulse_errs: got valid=%b errs=%b%b expected 0 00",
                     bus.if_valid, bus.err_misalign, bus.err_timeout);
        end
    endtask

    task automatic test_write();
        int n;
        ack_delay = 0;
        bus.dm_addr  = 32'h100;
        bus.dm_wdata = 32'h55;
        bus.dm_we    = 1'b1;
        bus.dm_req   = 1'b1;
        n = 0;
        while (!bus.mem_req && n < 20) begin @(negedge clk); n++; end
        vectors++;
        if ({bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_wdata} !== {1'b1, 30'h40, 1'b1, 32'h55}) begin
            miscompares++;
            $display("FAIL write_grant: got req=%b addr=%h we=%b wdata=%h expected 1 40 1 55",
                     bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_wdata);
        end
        n = 0;
        while (bus.mem_req && n < 300) begin n++; @(negedge clk); end
        vectors++;
        if (n != 1 || bus.dm_valid !== 1'b1 || bus.if_valid !== 1'b0 || bus.dm_rdata !== exp_dm_rdata) begin
            miscompares++;
            $display("FAIL write_complete: got busy=%0d dvalid=%b ivalid=%b rdata=%h expected 1 1 0 %h",
                     n, bus.dm_valid, bus.if_valid, bus.dm_rdata, exp_dm_rdata);
        end
        ref_mem[8'h40] = 32'h55;
        drop_all();
        @(negedge clk);
        vectors++;
        if (bus.dm_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL write_pulse: got dm_valid=%b expected 0", bus.dm_valid);
        end
    endtask

    task automatic test_starve();
        int cons, grants, n;
        bit both, prev, exp_i;
        ack_delay = 0;
        bus.if_addr = 30'h2000_0010;
        bus.dm_addr = 32'h80;
        bus.dm_we   = 1'b0;
        bus.if_req  = 1'b1;
        bus.dm_req  = 1'b1;
        cons = 0; grants = 0; both = 1'b0;
        prev = bus.mem_req;
        for (int c = 0; c < 300 && grants < 10; c++) begin
            @(negedge clk);
            if (bus.if_valid && bus.dm_valid) both = 1'b1;
            if (bus.mem_req && !prev) begin
                exp_i = (cons >= STARVE_MAX);
                cons  = exp_i ? 0 : cons + 1;
                vectors++;
                if ((bus.mem_addr == bus.if_addr) != exp_i) begin
                    miscompares++;
                    $display("FAIL starve_grant%0d: got fetch=%b expected fetch=%b", grants,
                             bus.mem_addr == bus.if_addr, exp_i);
                end
                grants++;
            end
            prev = bus.mem_req;
        end
        vectors++;
        if (grants != 10 || both) begin
            miscompares++;
            $display("FAIL starve_run: got grants=%0d both_valid=%b expected 10 0", grants, both);
        end
        drop_all();
        n = 0;
        while (!bus.if_valid && !bus.dm_valid && n < 20) begin @(negedge clk); n++; end
        vectors++;
        if (bus.if_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL dropped_req_completes: got if_valid=%b dm_valid=%b expected 1 0",
                     bus.if_valid, bus.dm_valid);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_misalign();
        int n;
        ack_delay = 1;
        bus.dm_addr = 32'h102;
        bus.dm_we   = 1'b0;
        bus.dm_req  = 1'b1;
        n = 0;
        while (!bus.mem_req && n < 20) begin @(negedge clk); n++; end
        vectors++;
        if ({bus.mem_addr, bus.mem_we, bus.err_misalign} !== {30'h40, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL misalign_grant: got addr=%h we=%b err=%b expected 40 0 1",
                     bus.mem_addr, bus.mem_we, bus.err_misalign);
        end
        n = 0;
        while (!bus.dm_valid && n < 20) begin @(negedge clk); n++; end
        vectors++;
        if (bus.dm_valid !== 1'b1 || bus.dm_rdata !== ref_mem[8'h40]) begin
            miscompares++;
            $display("FAIL misalign_read: got valid=%b rdata=%h expected 1 %h",
                     bus.dm_valid, bus.dm_rdata, ref_mem[8'h40]);
        end
        exp_dm_rdata = ref_mem[8'h40];
        drop_all();
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.err_misalign !== 1'b1) begin
            miscompares++;
            $display("FAIL misalign_sticky: got %b expected 1", bus.err_misalign);
        end
    endtask

    task automatic test_timeout();
        int n;
        ack_en = 1'b0;
        bus.if_addr = 30'h7;
        bus.if_req  = 1'b1;
        n = 0;
        while (!bus.mem_req && n < 20) begin @(negedge clk); n++; end
        n = 0;
        while (bus.mem_req && n < 300) begin n++; @(negedge clk); end
        vectors++;
        if (n != TIMEOUT || {bus.if_valid, bus.err_timeout} !== 2'b11 || bus.if_rdata !== ERR_WORD) begin
            miscompares++;
            $display("FAIL timeout: got busy=%0d valid=%b err=%b rdata=%h expected %0d 1 1 %h",
                     n, bus.if_valid, bus.err_timeout, bus.if_rdata, TIMEOUT, ERR_WORD);
        end
        bus.if_req = 1'b0;
        ack_en = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n;
        bit activity;
        ack_en = 1'b0;
        bus.dm_addr = 32'h200;
        bus.dm_we   = 1'b0;
        bus.dm_req  = 1'b1;
        n = 0;
        while (!bus.mem_req && n < 20) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        drop_all();
        @(negedge clk);
        vectors++;
        if (outs() !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: got %h expected 0", outs());
        end
        rst = 1'b0;
        exp_dm_rdata = '0;
        late_ack_tok++;
        activity = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.dm_valid || bus.if_valid || bus.mem_req) activity = 1'b1;
        end
        vectors++;
        if (activity) begin
            miscompares++;
            $display("FAIL late_ack_ignored: got activity=1 expected 0");
        end
        ack_en = 1'b1;
        ack_delay = 0;
        bus.if_addr = 30'h2000_0003;
        bus.if_req  = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus.mem_req, bus.mem_addr} !== {1'b1, 30'h2000_0003}) begin
            miscompares++;
            $display("FAIL idle_after_reset: got req=%b addr=%h expected 1 20000003",
                     bus.mem_req, bus.mem_addr);
        end
        n = 0;
        while (!bus.if_valid && n < 20) begin @(negedge clk); n++; end
        bus.if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        bit snap_i, snap_d, prev_req, both, dwe;
        int cons_d, out_kind, completions;
        logic [29:0] ia;
        logic [31:0] da, dw, exp;
        cons_d = 0; out_kind = -1; completions = 0; both = 1'b0;
        ia = '0; da = '0; dw = '0; dwe = 1'b0;
        ack_en = 1'b1;
        ack_delay = $urandom_range(0, 4);
        prev_req = bus.mem_req;
        snap_i = bus.if_req;
        snap_d = bus.dm_req;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (bus.mem_req && !prev_req) begin
                int exp_kind, obs_kind;
                if (snap_d && (!snap_i || cons_d < STARVE_MAX)) exp_kind = 1;
                else if (snap_i) exp_kind = 0;
                else exp_kind = -1;
                cons_d   = (exp_kind == 1 && snap_i) ? cons_d + 1 : 0;
                obs_kind = bus.mem_addr[29] ? 0 : 1;
                vectors++;
                if (obs_kind != exp_kind ||
                    (obs_kind == 0 && {bus.mem_addr, bus.mem_we} !== {ia, 1'b0}) ||
                    (obs_kind == 1 && {bus.mem_addr, bus.mem_we, bus.mem_wdata} !== {da[31:2], dwe, dw})) begin
                    miscompares++;
                    $display("FAIL rand_grant: got kind=%0d addr=%h we=%b wdata=%h expected kind=%0d",
                             obs_kind, bus.mem_addr, bus.mem_we, bus.mem_wdata, exp_kind);
                end
                out_kind = exp_kind;
            end
            if (bus.if_valid && bus.dm_valid) both = 1'b1;
            if (bus.if_valid) begin
                vectors++;
                if (out_kind != 0 || bus.if_rdata !== ref_mem[ia[7:0]]) begin
                    miscompares++;
                    $display("FAIL rand_fetch: got kind=%0d rdata=%h expected kind=0 rdata=%h",
                             out_kind, bus.if_rdata, ref_mem[ia[7:0]]);
                end
                completions++;
                out_kind   = -1;
                bus.if_req = 1'b0;
                ack_delay  = $urandom_range(0, 4);
            end
            if (bus.dm_valid) begin
                exp = dwe ? exp_dm_rdata : ref_mem[da[9:2]];
                vectors++;
                if (out_kind != 1 || bus.dm_rdata !== exp) begin
                    miscompares++;
                    $display("FAIL rand_data: got kind=%0d rdata=%h expected kind=1 rdata=%h",
                             out_kind, bus.dm_rdata, exp);
                end
                if (dwe) ref_mem[da[9:2]] = dw;
                else exp_dm_rdata = exp;
                completions++;
                out_kind   = -1;
                bus.dm_req = 1'b0;
                ack_delay  = $urandom_range(0, 4);
            end
            if (cyc < 2950 && !bus.if_req && $urandom_range(0, 3) == 0) begin
                ia = {1'b1, 29'($urandom)};
                bus.if_addr = ia;
                bus.if_req  = 1'b1;
            end
            if (cyc < 2950 && !bus.dm_req && $urandom_range(0, 2) == 0) begin
                da  = {1'b0, 29'($urandom), 2'b00};
                dw  = $urandom;
                dwe = 1'($urandom_range(0, 1));
                bus.dm_addr  = da;
                bus.dm_wdata = dw;
                bus.dm_we    = dwe;
                bus.dm_req   = 1'b1;
            end
            snap_i   = bus.if_req;
            snap_d   = bus.dm_req;
            prev_req = bus.mem_req;
        end
        vectors++;
        if (bus.if_req || bus.dm_req || both || completions < 100 ||
            {bus.err_misalign, bus.err_timeout} !== 2'b00) begin
            miscompares++;
            $display("FAIL rand_summary: got pend=%b%b both=%b done=%0d errs=%b%b expected 00 0 >=100 00",
                     bus.if_req, bus.dm_req, both, completions, bus.err_misalign, bus.err_timeout);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        test_reset();
        test_fetch();
        test_write();
        test_starve();
        test_misalign();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
